// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature decoder: {A,B} state encodings,
// counting-resolution constants and the step-classification helpers.
package quad_pkg;

    // Filtered {A,B} levels; forward rotation is S00 -> S10 -> S11 -> S01 -> S00
    typedef enum logic [1:0] {
        S00 = 2'b00,
        S10 = 2'b10,
        S11 = 2'b11,
        S01 = 2'b01
    } quad_state_t;

    localparam int RES_X1 = 1;
    localparam int RES_X2 = 2;
    localparam int RES_X4 = 4;

    // Next state one step forward
    function automatic quad_state_t step_fwd(input quad_state_t s);
        case (s)
            S00:     return S10;
            S10:     return S11;
            S11:     return S01;
            default: return S00;
        endcase
    endfunction

    // Whether a forward step leaving 'from' emits an up pulse
    function automatic logic fwd_counted(input quad_state_t from, input int res);
        case (res)
            RES_X4:  return 1'b1;
            RES_X2:  return (from == S00) || (from == S11);
            default: return (from == S00);
        endcase
    endfunction

    // Whether a reverse step leaving 'from' emits a down pulse
    function automatic logic rev_counted(input quad_state_t from, input int res);
        case (res)
            RES_X4:  return 1'b1;
            RES_X2:  return (from == S10) || (from == S01);
            default: return (from == S10);
        endcase
    endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Encoder inputs and decoded pulse outputs of the quadrature decoder.
interface quad_decoder_if;
    logic a;
    logic b;
    logic z;
    logic err_clr;
    logic up;
    logic down;
    logic index;
    logic err;
    logic err_flag;

    modport master (
        output a, b, z, err_clr,
        input  up, down, index, err, err_flag
    );

    modport slave (
        input  a, b, z, err_clr,
        output up, down, index, err, err_flag
    );
endinterface

// File: rtl/quad_filter.sv
// Two-flop synchronizer followed by a glitch filter: the output follows the
// synchronized level only once it has differed for FILTER_LEN cycles in a row.
module quad_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);
    // Counter only ever holds 0..FILTER_LEN-1, so it cannot wrap
    localparam int            CW   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

    logic          sync1_d, sync1_q;
    logic          sync2_d, sync2_q;
    logic          filt_d,  filt_q;
    logic [CW-1:0] cnt_d,   cnt_q;

    // Count consecutive disagreeing cycles; any agreement discards the run
    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        filt_d  = filt_q;
        cnt_d   = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == LAST) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer, filter output and stability counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = filt_q;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filters A/B (and optionally Z), classifies each change
// of the filtered {A,B} state and emits registered one-cycle pulses.
// Optional feature: define QUAD_DECODER_INDEX_EN to build the Z index path;
// otherwise the z input is ignored and index is tied low.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int RESOLUTION = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    quad_decoder_if.slave bus
);
    // After reset, the filters need FILTER_LEN+2 cycles to reach the input
    // level and one more to reach ab_cur_q; decisions are held off until
    // ab_prev_q has been loaded from that settled value.
    localparam int ARM_CYCLES = FILTER_LEN + 4;
    localparam int AW         = $clog2(ARM_CYCLES + 1);

    generate
        if (RESOLUTION != RES_X1 && RESOLUTION != RES_X2 && RESOLUTION != RES_X4) begin : g_bad_res
            $fatal(1, "quad_decoder: RESOLUTION must be 1, 2 or 4");
        end
        if (FILTER_LEN < 1 || FILTER_LEN > 255) begin : g_bad_len
            $fatal(1, "quad_decoder: FILTER_LEN must be 1..255");
        end
    endgenerate

    logic filt_a;
    logic filt_b;

    quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (bus.a),
        .dout    (filt_a)
    );

    quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (bus.b),
        .dout    (filt_b)
    );

    quad_state_t   ab_cur_d,   ab_cur_q;
    quad_state_t   ab_prev_d,  ab_prev_q;
    logic [AW-1:0] arm_cnt_d,  arm_cnt_q;
    logic          up_d,       up_q;
    logic          down_d,     down_q;
    logic          err_d,      err_q;
    logic          err_flag_d, err_flag_q;

    // Classify the step from ab_prev_q to ab_cur_q once armed
    always_comb begin
        ab_cur_d   = quad_state_t'({filt_a, filt_b});
        ab_prev_d  = ab_cur_q;
        arm_cnt_d  = arm_cnt_q;
        up_d       = 1'b0;
        down_d     = 1'b0;
        err_d      = 1'b0;
        if (arm_cnt_q != '0) begin
            arm_cnt_d = arm_cnt_q - 1'b1;
        end else if (ab_cur_q != ab_prev_q) begin
            if (ab_cur_q == step_fwd(ab_prev_q)) begin
                up_d = fwd_counted(ab_prev_q, RESOLUTION);
            end else if (ab_prev_q == step_fwd(ab_cur_q)) begin
                down_d = rev_counted(ab_prev_q, RESOLUTION);
            end else begin
                err_d = 1'b1;
            end
        end
        // A new error wins over a simultaneous clear
        err_flag_d = err_d ? 1'b1 : (bus.err_clr ? 1'b0 : err_flag_q);
    end

    // State history, arming timer and registered pulse outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ab_cur_q   <= S00;
            ab_prev_q  <= S00;
            arm_cnt_q  <= AW'(ARM_CYCLES);
            up_q       <= 1'b0;
            down_q     <= 1'b0;
            err_q      <= 1'b0;
            err_flag_q <= 1'b0;
        end else begin
            ab_cur_q   <= ab_cur_d;
            ab_prev_q  <= ab_prev_d;
            arm_cnt_q  <= arm_cnt_d;
            up_q       <= up_d;
            down_q     <= down_d;
            err_q      <= err_d;
            err_flag_q <= err_flag_d;
        end
    end

    assign bus.up       = up_q;
    assign bus.down     = down_q;
    assign bus.err      = err_q;
    assign bus.err_flag = err_flag_q;

`ifdef QUAD_DECODER_INDEX_EN
    logic filt_z;
    logic z_cur_d,  z_cur_q;
    logic z_prev_d, z_prev_q;
    logic index_d,  index_q;

    quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_z (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (bus.z),
        .dout    (filt_z)
    );

    // Rising edge of filtered z, aligned with the A/B pulse latency
    always_comb begin
        z_cur_d  = filt_z;
        z_prev_d = z_cur_q;
        index_d  = (arm_cnt_q == '0) && z_cur_q && !z_prev_q;
    end

    // Index edge history and registered index pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            z_cur_q  <= 1'b0;
            z_prev_q <= 1'b0;
            index_q  <= 1'b0;
        end else begin
            z_cur_q  <= z_cur_d;
            z_prev_q <= z_prev_d;
            index_q  <= index_d;
        end
    end

    assign bus.index = index_q;
`else
    logic z_unused;
    assign z_unused  = bus.z;
    assign bus.index = 1'b0;
`endif

endmodule
